fir_decim_accum: RTL and testbench
==================================

FIR_DECIM_ACCUM -- requirements
Module: fir_decim_accum

Interface
REQ-001 SHALL have parameter PROD_W, default 31, meaning signed product width (16s x 15ns multiplier output).
REQ-002 SHALL have parameter ACC_W, default 36, meaning accumulator width (PROD_W + 5 guard bits).
REQ-003 SHALL have parameter OUT_W, default 16, meaning output sample width.
REQ-004 SHALL have parameter FRAC_SHIFT, default 15, meaning right shift removing Q0.15 coefficient scaling.
REQ-005 SHALL have parameter DECIM, default 4, meaning decimation factor (valid range 1..16).
REQ-006 SHALL have parameter MAX_TAPS, default 32, meaning maximum products per output frame.
REQ-007 SHALL have port ap_clk, input, 1 bit, meaning the single clock; all logic on its rising edge.
REQ-008 SHALL have port ap_rst_n, input, 1 bit, meaning the reset, asynchronous and active-low.
REQ-009 SHALL have port prod_data, input, PROD_W bits, meaning the signed product.
REQ-010 SHALL have port prod_valid, input, 1 bit, meaning prod_data is valid.
REQ-011 SHALL have port prod_last, input, 1 bit, meaning the current product is the final tap of the frame.
REQ-012 SHALL have port prod_ready, output, 1 bit, meaning the block accepts a product this cycle.
REQ-013 SHALL have port out_data, output, OUT_W bits, meaning the signed decimated sample.
REQ-014 SHALL have port out_valid, output, 1 bit, meaning out_data is valid.
REQ-015 SHALL have port out_ready, input, 1 bit, meaning the consumer accepts out_data.
REQ-016 SHALL have port sat_err, output, 1 bit, meaning sticky flag for output saturation.
REQ-017 SHALL have port tap_err, output, 1 bit, meaning sticky flag for a frame exceeding MAX_TAPS.

Function
REQ-018 A product SHALL be accepted only in a cycle where prod_valid and prod_ready are both high.
REQ-019 The first accepted product of a frame SHALL load acc with sign-extended prod_data; subsequent products SHALL add to acc.
REQ-020 A tap counter SHALL count accepted products in the frame; the MAX_TAPS+1-th product without prod_last SHALL set tap_err.
REQ-021 After REQ-020 fires, the block SHALL keep accumulating without wrapping the counter until prod_last arrives.
REQ-022 On acceptance with prod_last, the block SHALL compute the final sum (acc plus current product) and clear the frame state, so the next product starts a new frame.
REQ-023 On each prod_last acceptance, the phase counter SHALL advance modulo DECIM.
REQ-024 When the phase equals 0 before advancing, the result SHALL be pushed to the output FIFO; all other frames SHALL be discarded.
REQ-025 Rounding SHALL add 2^(FRAC_SHIFT-1), arithmetic-shift right by FRAC_SHIFT, then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-026 Any clipping under REQ-025 SHALL set sat_err.
REQ-027 The output FIFO SHALL be 2 entries deep, registered; out_valid SHALL be high when count is nonzero; out_data SHALL be the head entry.
REQ-028 Latency SHALL be 1 cycle from prod_last acceptance to out_valid high, when the FIFO was empty.
REQ-029 prod_ready SHALL be low when FIFO count equals 2, and high otherwise.
REQ-030 A simultaneous push and pop at count 1 SHALL leave count at 1 with the new entry at head.
REQ-031 A pop without a push SHALL decrement count.
REQ-032 out_data SHALL remain stable while out_valid is high and out_ready is low.

Reset
REQ-033 Asserting ap_rst_n low SHALL immediately clear acc, the tap counter, the phase counter (to 0), the FIFO (count 0), out_data (to 0), out_valid, sat_err and tap_err, and SHALL set the frame state to "first product".
REQ-034 During reset, prod_ready SHALL be low.
REQ-035 A reset asserted mid-frame SHALL discard the partial frame; the first product after release SHALL start a new frame at phase 0.

Structure
REQ-036 Package multirate_pkg SHALL hold the PROD_W, ACC_W, OUT_W, FRAC_SHIFT, DECIM and MAX_TAPS defaults and the rounding constant.
REQ-037 The output FIFO SHALL be a sub-module named multirate_fifo2; the accumulator, counters and rounding SHALL stay in fir_decim_accum.

Verification
REQ-038 Rounding (DECIM=1): single-tap frames 16383, 16384 and -49152 -> out_data 0, 1 and -1.
REQ-039 Accumulate (DECIM=1): 4 products of 16384, last on the 4th -> out_data 2, one cycle after the last acceptance.
REQ-040 Saturation: 32 products of 2^30-1 -> out_data 32767 and sat_err=1; 32 products of -2^30 -> out_data -32768.
REQ-041 Decimation: DECIM=4, single-tap frames 1*32768 .. 8*32768 -> only 1 and 5 are output; after a mid-sequence reset, the next frame is output.
REQ-042 Backpressure: out_ready low with 3 frames sent -> 2 buffered, prod_ready low; out_ready high -> outputs in order with no loss.
REQ-043 Tap overflow: 33 products, last on the 33rd -> tap_err=1, which holds until reset.

Source files
------------

// File: rtl/multirate_pkg.sv
// Shared defaults and helpers for the multirate FIR post-processing blocks.
// Holds datapath widths, decimation limits and the round-half-up constant.
package multirate_pkg;

    localparam int PROD_W_DEF     = 31;
    localparam int ACC_W_DEF      = 36;
    localparam int OUT_W_DEF      = 16;
    localparam int FRAC_SHIFT_DEF = 15;
    localparam int DECIM_DEF      = 4;
    localparam int MAX_TAPS_DEF   = 32;

    // Phase counter is wide enough for the largest supported decimation (16).
    localparam int PHASE_W = 4;

    typedef enum logic {
        FRAME_FIRST,
        FRAME_ACCUM
    } frame_state_t;

    function automatic longint round_const(input int shift);
        return longint'(1) << (shift - 1);
    endfunction

    localparam longint ROUND_CONST = round_const(FRAC_SHIFT_DEF);

endpackage

// File: rtl/multirate_fifo2.sv
// Two-entry registered output FIFO; entry 0 is always the head and drives data.
// A pop shifts entry 1 down, so a push during a pop at count 1 lands at the head.
module multirate_fifo2
    import multirate_pkg::*;
#(
    parameter int W = OUT_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] data,
    output logic         valid,
    output logic         full
);

    logic [W-1:0] mem_reg [2];
    logic [1:0]   count_reg, count_next;
    logic         load_en  [2];
    logic [W-1:0] load_val [2];
    logic         push_eff, pop_eff;

    assign valid = (count_reg != 2'd0);
    assign full  = (count_reg == 2'd2);
    assign data  = mem_reg[0];

    always_comb begin
        pop_eff     = pop && (count_reg != 2'd0);
        push_eff    = push && ((count_reg != 2'd2) || pop_eff);
        count_next  = count_reg + {1'b0, push_eff} - {1'b0, pop_eff};
        load_en[0]  = 1'b0;
        load_val[0] = push_data;
        load_en[1]  = 1'b0;
        load_val[1] = push_data;
        if (pop_eff) begin
            if (count_reg == 2'd2) begin
                load_en[0]  = 1'b1;
                load_val[0] = mem_reg[1];
                load_en[1]  = push_eff;
            end else begin
                load_en[0]  = push_eff;
            end
        end else if (push_eff) begin
            if (count_reg == 2'd0) begin
                load_en[0] = 1'b1;
            end else begin
                load_en[1] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= 2'd0;
        end else begin
            count_reg <= count_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_reg[gi] <= '0;
                end else if (load_en[gi]) begin
                    mem_reg[gi] <= load_val[gi];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/fir_decim_accum.sv
// FIR tail: accumulates per-tap products into frames, keeps one frame in DECIM,
// rounds/saturates the kept sums and queues them in a two-entry output FIFO.
module fir_decim_accum
    import multirate_pkg::*;
#(
    parameter int PROD_W     = PROD_W_DEF,
    parameter int ACC_W      = ACC_W_DEF,
    parameter int OUT_W      = OUT_W_DEF,
    parameter int FRAC_SHIFT = FRAC_SHIFT_DEF,
    parameter int DECIM      = DECIM_DEF,
    parameter int MAX_TAPS   = MAX_TAPS_DEF
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic [PROD_W-1:0] prod_data,
    input  logic              prod_valid,
    input  logic              prod_last,
    output logic              prod_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sat_err,
    output logic              tap_err
);

    localparam int TAP_W = $clog2(MAX_TAPS + 1);
    localparam int SUM_W = ACC_W + 1;

    localparam logic signed [SUM_W-1:0] ROUND_K = SUM_W'(round_const(FRAC_SHIFT));
    localparam logic signed [SUM_W-1:0] OUT_MAX = SUM_W'((longint'(1) << (OUT_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] OUT_MIN = -OUT_MAX - SUM_W'(1);

    frame_state_t              state_reg, state_next;
    logic signed [ACC_W-1:0]   acc_reg, acc_next;
    logic [TAP_W-1:0]          tap_reg, tap_next;
    logic [PHASE_W-1:0]        phase_reg, phase_next;
    logic                      sat_err_reg, sat_err_next;
    logic                      tap_err_reg, tap_err_next;

    logic                      accept, push, fifo_full, clipped;
    logic signed [ACC_W-1:0]   prod_ext, sum;
    logic signed [SUM_W-1:0]   biased, shifted;
    logic [OUT_W-1:0]          rounded;

    assign prod_ready = ap_rst_n && !fifo_full;
    assign accept     = prod_valid && prod_ready;
    assign sat_err    = sat_err_reg;
    assign tap_err    = tap_err_reg;

    // The first product of a frame replaces the stale accumulator contents.
    assign prod_ext = ACC_W'($signed(prod_data));
    assign sum      = ((state_reg == FRAME_FIRST) ? '0 : acc_reg) + prod_ext;
    assign biased   = SUM_W'(sum) + ROUND_K;
    assign shifted  = biased >>> FRAC_SHIFT;

    always_comb begin
        clipped = 1'b0;
        rounded = shifted[OUT_W-1:0];
        if (shifted > OUT_MAX) begin
            clipped = 1'b1;
            rounded = OUT_MAX[OUT_W-1:0];
        end else if (shifted < OUT_MIN) begin
            clipped = 1'b1;
            rounded = OUT_MIN[OUT_W-1:0];
        end
    end

    always_comb begin
        state_next   = state_reg;
        acc_next     = acc_reg;
        tap_next     = tap_reg;
        phase_next   = phase_reg;
        sat_err_next = sat_err_reg;
        tap_err_next = tap_err_reg;
        push         = 1'b0;
        if (accept) begin
            // Counter parks at MAX_TAPS once the frame overruns.
            if (tap_reg == TAP_W'(MAX_TAPS)) begin
                tap_err_next = 1'b1;
            end else begin
                tap_next = tap_reg + TAP_W'(1);
            end
            if (prod_last) begin
                state_next = FRAME_FIRST;
                acc_next   = '0;
                tap_next   = '0;
                phase_next = (phase_reg == PHASE_W'(DECIM - 1)) ? '0 : phase_reg + PHASE_W'(1);
                if (phase_reg == '0) begin
                    push = 1'b1;
                    if (clipped) begin
                        sat_err_next = 1'b1;
                    end
                end
            end else begin
                state_next = FRAME_ACCUM;
                acc_next   = sum;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_reg   <= FRAME_FIRST;
            acc_reg     <= '0;
            tap_reg     <= '0;
            phase_reg   <= '0;
            sat_err_reg <= 1'b0;
            tap_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            acc_reg     <= acc_next;
            tap_reg     <= tap_next;
            phase_reg   <= phase_next;
            sat_err_reg <= sat_err_next;
            tap_err_reg <= tap_err_next;
        end
    end

    multirate_fifo2 #(
        .W (OUT_W)
    ) u_fifo (
        .clk       (ap_clk),
        .rst_n     (ap_rst_n),
        .push      (push),
        .push_data (rounded),
        .pop       (out_ready),
        .data      (out_data),
        .valid     (out_valid),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_fir_decim_accum.sv
// Scoreboard bench: dut 0 runs DECIM=1 (rounding, accumulate, saturation,
// backpressure, tap overflow), dut 1 runs DECIM=4 (decimation, mid-frame reset).
module tb_fir_decim_accum;

    localparam int PW = 31;
    localparam int OW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n [2];
    logic signed [PW-1:0] pd    [2];
    logic                 pv    [2];
    logic                 pl    [2];
    logic                 ordy  [2];
    logic                 pr    [2];
    logic                 ov    [2];
    logic                 se    [2];
    logic                 te    [2];
    logic [OW-1:0]        od    [2];

    fir_decim_accum #(.DECIM(1)) u_dut_a (
        .ap_clk(clk), .ap_rst_n(rst_n[0]), .prod_data(pd[0]), .prod_valid(pv[0]),
        .prod_last(pl[0]), .prod_ready(pr[0]), .out_data(od[0]), .out_valid(ov[0]),
        .out_ready(ordy[0]), .sat_err(se[0]), .tap_err(te[0])
    );

    fir_decim_accum #(.DECIM(4)) u_dut_b (
        .ap_clk(clk), .ap_rst_n(rst_n[1]), .prod_data(pd[1]), .prod_valid(pv[1]),
        .prod_last(pl[1]), .prod_ready(pr[1]), .out_data(od[1]), .out_valid(ov[1]),
        .out_ready(ordy[1]), .sat_err(se[1]), .tap_err(te[1])
    );

    logic signed [OW-1:0] exp_a [$];
    logic signed [OW-1:0] exp_b [$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic expect_out(input int s, input int v);
        if (s == 0) exp_a.push_back(OW'(v));
        else        exp_b.push_back(OW'(v));
    endtask

    task automatic send(input int s, input longint data, input logic last);
        bit got;
        got   = 1'b0;
        pd[s] = PW'(data);
        pl[s] = last;
        pv[s] = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (pr[s]) got = 1'b1;
        end
        if (got) begin
            @(posedge clk);
            #1;
            $display("txn dut%0d product=%0d last=%0b accepted", s, data, last);
        end else begin
            check("send_timeout", 0, 1);
        end
        pv[s] = 1'b0;
        pl[s] = 1'b0;
    endtask

    task automatic drain(input int s);
        for (int i = 0; i < 100; i++) begin
            if ((s == 0 ? exp_a.size() : exp_b.size()) == 0 && !ov[s]) break;
            @(posedge clk);
            #1;
        end
        check(s == 0 ? "a_drained" : "b_drained", s == 0 ? exp_a.size() : exp_b.size(), 0);
    endtask

    // Monitors: pop expected values when a sample is handed over.
    logic signed [OW-1:0] prev_a, prev_b;
    bit stall_a = 1'b0, stall_b = 1'b0;

    always @(negedge clk) begin
        logic signed [OW-1:0] e;
        if (rst_n[0] && ov[0]) begin
            if (stall_a) check("a_stable", $signed(od[0]), prev_a);
            if (ordy[0]) begin
                if (exp_a.size() == 0) begin
                    check("a_unexpected_out", $signed(od[0]), 99999);
                end else begin
                    e = exp_a.pop_front();
                    check("a_out_data", $signed(od[0]), e);
                    $display("txn dut0 out_data=%0d expected=%0d", $signed(od[0]), e);
                end
            end
        end
        stall_a = rst_n[0] && ov[0] && !ordy[0];
        prev_a  = $signed(od[0]);
    end

    always @(negedge clk) begin
        logic signed [OW-1:0] e;
        if (rst_n[1] && ov[1]) begin
            if (stall_b) check("b_stable", $signed(od[1]), prev_b);
            if (ordy[1]) begin
                if (exp_b.size() == 0) begin
                    check("b_unexpected_out", $signed(od[1]), 99999);
                end else begin
                    e = exp_b.pop_front();
                    check("b_out_data", $signed(od[1]), e);
                    $display("txn dut1 out_data=%0d expected=%0d", $signed(od[1]), e);
                end
            end
        end
        stall_b = rst_n[1] && ov[1] && !ordy[1];
        prev_b  = $signed(od[1]);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            rst_n[s] = 1'b0; pd[s] = '0; pv[s] = 1'b0; pl[s] = 1'b0; ordy[s] = 1'b1;
        end
        repeat (2) @(negedge clk);
        check("rst_prod_ready", pr[0], 0);
        check("rst_out_valid", ov[0], 0);
        check("rst_out_data", od[0], 0);
        check("rst_sat_err", se[0], 0);
        check("rst_tap_err", te[0], 0);
        check("rst_prod_ready_b", pr[1], 0);
        @(posedge clk); #1;
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(negedge clk);
        check("ready_after_rst", pr[0], 1);
        @(posedge clk); #1;

        // Rounding: single-tap frames
        expect_out(0, 0);  send(0, 16383, 1'b1);
        expect_out(0, 1);  send(0, 16384, 1'b1);
        expect_out(0, -1); send(0, -49152, 1'b1);
        drain(0);

        // Accumulate four taps, with one-cycle latency
        expect_out(0, 2);
        for (int i = 0; i < 4; i++) begin
            send(0, 16384, i == 3);
            if (i == 2) check("acc_not_early", ov[0], 0);
        end
        check("acc_latency", ov[0], 1);
        drain(0);
        check("sat_err_clear", se[0], 0);

        // Saturation, positive then negative
        expect_out(0, 32767);
        for (int i = 0; i < 32; i++) send(0, (64'sd1 <<< 30) - 1, i == 31);
        drain(0);
        check("sat_err_set", se[0], 1);
        check("tap_err_32_taps", te[0], 0);
        expect_out(0, -32768);
        for (int i = 0; i < 32; i++) send(0, -(64'sd1 <<< 30), i == 31);
        drain(0);

        // Backpressure: two buffered, third held off
        ordy[0] = 1'b0;
        expect_out(0, 10); send(0, 10 * 32768, 1'b1);
        expect_out(0, 11); send(0, 11 * 32768, 1'b1);
        pd[0] = PW'(12 * 32768); pl[0] = 1'b1; pv[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_prod_ready_low", pr[0], 0);
        end
        check("bp_out_valid", ov[0], 1);
        check("bp_head", $signed(od[0]), 10);
        @(posedge clk); #1;
        ordy[0] = 1'b1;
        expect_out(0, 12); send(0, 12 * 32768, 1'b1);
        drain(0);

        // Tap overflow: 33 taps then sticky until reset
        expect_out(0, 0);
        for (int i = 0; i < 33; i++) begin
            if (i == 32) check("tap_err_before_33", te[0], 0);
            send(0, 1, i == 32);
        end
        check("tap_err_set", te[0], 1);
        expect_out(0, 0); send(0, 1, 1'b1);
        drain(0);
        check("tap_err_sticky", te[0], 1);
        rst_n[0] = 1'b0;
        @(negedge clk);
        check("tap_err_rst", te[0], 0);
        check("sat_err_rst", se[0], 0);
        check("rst_ready_low", pr[0], 0);
        @(posedge clk); #1;
        rst_n[0] = 1'b1;

        // Decimation by 4: frames 1..8 keep only 1 and 5
        for (int k = 1; k <= 8; k++) begin
            if (k == 1 || k == 5) expect_out(1, k);
            send(1, k * 32768, 1'b1);
        end
        expect_out(1, 1); send(1, 32768, 1'b1);
        send(1, 2 * 32768, 1'b1);
        send(1, 100 * 32768, 1'b0);
        rst_n[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n[1] = 1'b1;
        expect_out(1, 7); send(1, 7 * 32768, 1'b1);
        drain(1);
        drain(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
